ula_multiciclo: RTL and testbench
=================================

Name: ula_multiciclo

Overview:
- Parametrised, registered, multi-cycle ALU for the multicycle MIPS datapath.
- Keeps the existing 4-bit operation encoding.
- Adds SLTU, three shifts, iterative unsigned multiply and unsigned divide, with a HI result register.
- Uses a start/busy/done handshake so the control FSM can stall on long operations.

Parameters:
- WIDTH, 32, operand and result width. Must be at least 4 and a power of two.
- SHW, log2(WIDTH), shift-amount width. Derived; not to be overridden.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- A      in  WIDTH  operand A; signed for ADD/SUB/SLT/SRA, otherwise unsigned
- B      in  WIDTH  operand B; shift amount is B[SHW-1:0]
- OP     in  4  operation select
- S      out  WIDTH  result: LO for MULT, quotient for DIVU
- HI     out  WIDTH  MULT upper half, DIVU remainder, 0 for all other ops
- Z      out  1  S == 0
- V      out  1  signed overflow; ADD and SUB only
- DZ     out  1  divide by zero; DIVU only
- busy   out  1  iterative operation in progress
- done   out  1  one-cycle pulse, results valid

Behaviour:
- Reset (async, active-high): FSM goes to IDLE; S, HI, Z, V, DZ, busy and done all go to 0, taking effect immediately, not at the next edge.
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 0011 XOR, 0100 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1101 MULT (unsigned), 1110 DIVU.
- Undefined opcodes complete as single-cycle with S=0, HI=0, Z=1.
- FSM states: IDLE, EXEC, DONE.
- Acceptance: start=1 in IDLE at edge N latches A, B and OP. Operand changes after edge N have no effect.
- Single-cycle ops:
  - Results are registered at edge N; done=1 for the cycle after edge N.
  - FSM passes through DONE and returns to IDLE at edge N+1.
  - busy stays 0 throughout.
  - Back-to-back start is accepted at edge N+1 (done=1 while in DONE counts as idle-ready).
- MULT and DIVU:
  - Edge N: enter EXEC with busy=1 and iteration counter cleared.
  - Edges N+1..N+WIDTH: one iteration each.
    - MULT: shift-add, product accumulated in HI:LO.
    - DIVU: restoring divide.
  - Edge N+WIDTH: S, HI, Z and DZ are updated, busy=0, done=1 for one cycle.
- start while busy=1 is ignored; there is no queueing.
- Outputs hold their last values until the next accepted operation completes. Intermediate partial products never appear on S or HI.
- Width and overflow rules:
  - ADD/SUB wrap modulo 2^WIDTH. V=1 when the operand signs and result sign show signed overflow.
  - SLT compares signed; SLTU compares unsigned. Both give S=1 or 0.
  - Shift amount is B[SHW-1:0]; the upper bits of B are ignored. SRA replicates A[WIDTH-1].
  - MULT produces the 2*WIDTH-bit unsigned product as {HI,S}.
- Divide by zero: DIVU with B=0 still takes WIDTH cycles and gives S = all ones, HI = A, DZ=1.
- Z is computed from the final S only.
- Reset mid-EXEC aborts the operation with no done pulse, and all outputs are 0. The first start after reset is handled normally.

Test Plan:
- ADD, WIDTH=32, A=0x7FFFFFFF, B=1 -> one cycle after acceptance: S=0x80000000, V=1, Z=0, done pulse 1 cycle, busy never high. Then SUB A=5, B=5 -> S=0, Z=1, V=0.
- SLT A=0xFFFFFFFF, B=1 -> S=1. SLTU with the same operands -> S=0. SRA A=0x80000000, B=0x24 (shift 4) -> S=0xF8000000. SRL with the same operands -> S=0x08000000.
- MULT A=B=0xFFFFFFFF -> busy high exactly 32 cycles, then HI=0xFFFFFFFE, S=0x00000001, Z=0, done pulse.
- DIVU A=100, B=7 -> S=14, HI=2, DZ=0 after 32 cycles. DIVU A=0x1234, B=0 -> S=0xFFFFFFFF, HI=0x1234, DZ=1.
- MULT started; start pulsed with OP=ADD at cycle 5 -> ignored, MULT result is unchanged. At cycle 10 of a second MULT, assert reset -> all outputs 0 immediately and no done pulse. After release, ADD 2+3 -> S=5.
- Re-instantiate with WIDTH=8: MULT 0xFF*0xFF -> HI=0xFE, S=0x01 after 8 cycles. SLL A=1, B=0x0F -> S=0x80.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered multi-cycle ALU for the multicycle MIPS datapath.
//
// Single-cycle ops register their result on the accepting edge and pulse
// done in the following cycle. MULT (shift-add) and DIVU (restoring) run
// WIDTH iterations with busy high, then update S/HI/Z/DZ and pulse done.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   start  operation request, sampled while not busy
//   A, B   operands (B[SHW-1:0] is the shift amount)
//   OP     4-bit operation select
//   S      result (LO for MULT, quotient for DIVU)
//   HI     MULT upper half, DIVU remainder, 0 otherwise
//   Z      S == 0
//   V      signed overflow (ADD/SUB)
//   DZ     divide by zero (DIVU)
//   busy   iterative operation in progress
//   done   one-cycle completion pulse
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] HI,
    output logic             Z,
    output logic             V,
    output logic             DZ,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLTU = 4'b0100,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_NOR  = 4'b1100,
        OP_MULT = 4'b1101,
        OP_DIVU = 4'b1110
    } op_t;

    state_t           state;
    op_t              op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [SHW-1:0]   cnt;
    // Shared iteration registers: HI:LO product for MULT,
    // remainder:quotient-shifter for DIVU.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    // Single-cycle datapath, fed straight from the ports on the accepting edge
    logic [WIDTH-1:0] sc_s;
    logic             sc_v;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SHW-1:0]   shamt;
    logic             is_multi;

    always_comb begin
        sc_s     = '0;
        sc_v     = 1'b0;
        sum      = A + B;
        dif      = A - B;
        shamt    = B[SHW-1:0];
        is_multi = (OP == OP_MULT) || (OP == OP_DIVU);
        case (OP)
            OP_AND:  sc_s = A & B;
            OP_OR:   sc_s = A | B;
            OP_XOR:  sc_s = A ^ B;
            OP_NOR:  sc_s = ~(A | B);
            OP_ADD: begin
                sc_s = sum;
                sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_s = dif;
                sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  sc_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_s = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  sc_s = A << shamt;
            OP_SRL:  sc_s = A >> shamt;
            OP_SRA:  sc_s = $unsigned($signed(A) >>> shamt);
            default: sc_s = '0;
        endcase
    end

    // One iteration of the multiply or divide
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_df;
    logic [WIDTH-1:0] nx_hi;
    logic [WIDTH-1:0] nx_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_r} : '0);
        div_sh  = {acc_hi, acc_lo[WIDTH-1]};
        // Remainder stays below a non-zero divisor, so bit WIDTH is a clean
        // borrow flag; with a zero divisor div_sh never reaches bit WIDTH.
        div_df  = div_sh - {1'b0, b_r};
        if (op_r == OP_DIVU) begin
            if (!div_df[WIDTH]) begin
                nx_hi = div_df[WIDTH-1:0];
                nx_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nx_hi = div_sh[WIDTH-1:0];
                nx_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nx_hi = mul_sum[WIDTH:1];
            nx_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_r   <= OP_AND;
            a_r    <= '0;
            b_r    <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            S      <= '0;
            HI     <= '0;
            Z      <= 1'b0;
            V      <= 1'b0;
            DZ     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (is_multi) begin
                            op_r   <= op_t'(OP);
                            a_r    <= A;
                            b_r    <= B;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= (OP == OP_DIVU) ? A : B;
                            busy   <= 1'b1;
                            state  <= EXEC;
                        end else begin
                            S     <= sc_s;
                            HI    <= '0;
                            Z     <= (sc_s == '0);
                            V     <= sc_v;
                            DZ    <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                EXEC: begin
                    acc_hi <= nx_hi;
                    acc_lo <= nx_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) begin
                        S     <= nx_lo;
                        HI    <= nx_hi;
                        Z     <= (nx_lo == '0);
                        V     <= 1'b0;
                        DZ    <= (op_r == OP_DIVU) && (b_r == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo at WIDTH=32 and WIDTH=8.
module tb_ula_multiciclo;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset32, reset8;
    logic        start32, start8;
    logic [31:0] a32, b32, s32, hi32;
    logic [7:0]  a8, b8, s8, hi8;
    logic [3:0]  op32, op8;
    logic        z32, v32, dz32, busy32, done32;
    logic        z8, v8, dz8, busy8, done8;

    ula_multiciclo #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset32), .start(start32), .A(a32), .B(b32), .OP(op32),
        .S(s32), .HI(hi32), .Z(z32), .V(v32), .DZ(dz32), .busy(busy32), .done(done32)
    );

    ula_multiciclo #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset8), .start(start8), .A(a8), .B(b8), .OP(op8),
        .S(s8), .HI(hi8), .Z(z8), .V(v8), .DZ(dz8), .busy(busy8), .done(done8)
    );

    typedef struct {
        logic [31:0] s;
        logic [31:0] hi;
        logic        z;
        logic        v;
        logic        dz;
        int          lat;  // edges from acceptance to the edge that raises done
        int          acc;  // edge count at acceptance
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bc32 = 0;
    int   bc8 = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        longint unsigned mask, ua, ub, r, h, p;
        longint sa, sb, t, maxs, mins;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        maxs = longint'((64'd1 << (w - 1)) - 64'd1);
        mins = -longint'(64'd1 << (w - 1));
        sa   = (ua > longint'(maxs)) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = (ub > longint'(maxs)) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        sh   = int'(ub % longint'(w));
        r = 0; h = 0; m.v = 1'b0; m.dz = 1'b0; m.lat = 0; m.acc = 0;
        case (op)
            4'b0000: r = ua & ub;
            4'b0001: r = ua | ub;
            4'b0011: r = ua ^ ub;
            4'b1100: r = ~(ua | ub) & mask;
            4'b0010: begin t = sa + sb; r = longint'(t) & mask; m.v = (t > maxs) || (t < mins); end
            4'b0110: begin t = sa - sb; r = longint'(t) & mask; m.v = (t > maxs) || (t < mins); end
            4'b0111: r = (sa < sb) ? 1 : 0;
            4'b0100: r = (ua < ub) ? 1 : 0;
            4'b1000: r = (ua << sh) & mask;
            4'b1001: r = ua >> sh;
            4'b1010: r = longint'(sa >>> sh) & mask;
            4'b1101: begin p = ua * ub; r = p & mask; h = p >> w; m.lat = w; end
            4'b1110: begin
                m.lat = w;
                if (ub == 0) begin r = mask; h = ua; m.dz = 1'b1; end
                else begin r = ua / ub; h = ua % ub; end
            end
            default: begin r = 0; h = 0; end
        endcase
        m.s  = r[31:0];
        m.hi = h[31:0];
        m.z  = (r == 0);
        return m;
    endfunction

    task automatic issue(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n;
        @(negedge clock);
        n = 0;
        while (((w == 8) ? busy8 : busy32) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL issue_wait busy still high after 200 cycles (w=%0d)", w);
        end
        e = model(w, op, a, b);
        e.acc = cyc + 1;
        if (w == 8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; q8.push_back(e);
        end else begin
            start32 = 1'b1; a32 = a; b32 = b; op32 = op; q32.push_back(e);
        end
        @(posedge clock);
        #1;
        // Scramble the inputs after acceptance; the DUT must have latched them
        if (w == 8) begin
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
        end else begin
            start32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset32) bc32 = 0;
        else begin
            if (busy32) bc32++;
            if (done32) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done32 actual=1 expected=0 (no pending op)");
                end else begin
                    e = q32.pop_front();
                    chk("s32", s32, e.s);
                    chk("hi32", hi32, e.hi);
                    chk("z32", {31'd0, z32}, {31'd0, e.z});
                    chk("v32", {31'd0, v32}, {31'd0, e.v});
                    chk("dz32", {31'd0, dz32}, {31'd0, e.dz});
                    chk("lat32", 32'(cyc - e.acc), 32'(e.lat));
                    chk("busycycles32", 32'(bc32), 32'(e.lat));
                end
                bc32 = 0;
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset8) bc8 = 0;
        else begin
            if (busy8) bc8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done8 actual=1 expected=0 (no pending op)");
                end else begin
                    e = q8.pop_front();
                    chk("s8", {24'd0, s8}, e.s);
                    chk("hi8", {24'd0, hi8}, e.hi);
                    chk("z8", {31'd0, z8}, {31'd0, e.z});
                    chk("v8", {31'd0, v8}, {31'd0, e.v});
                    chk("dz8", {31'd0, dz8}, {31'd0, e.dz});
                    chk("lat8", 32'(cyc - e.acc), 32'(e.lat));
                    chk("busycycles8", 32'(bc8), 32'(e.lat));
                end
                bc8 = 0;
            end
        end
    end

    task automatic chk_zero32(input string tag);
        chk({tag, "_s"}, s32, 32'd0);
        chk({tag, "_hi"}, hi32, 32'd0);
        chk({tag, "_flags"}, {27'd0, z32, v32, dz32, busy32, done32}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset32 = 1'b1; reset8 = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; op32 = '0;
        a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(negedge clock);
        chk_zero32("reset");
        chk("reset8_flags", {27'd0, z8, v8, dz8, busy8, done8}, 32'd0);
        reset32 = 1'b0; reset8 = 1'b0;

        // Directed cases, WIDTH=32
        issue(32, 4'b0010, 32'h7FFF_FFFF, 32'd1);
        issue(32, 4'b0110, 32'd5, 32'd5);
        issue(32, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        issue(32, 4'b0100, 32'hFFFF_FFFF, 32'd1);
        issue(32, 4'b1010, 32'h8000_0000, 32'h24);
        issue(32, 4'b1001, 32'h8000_0000, 32'h24);
        issue(32, 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32, 4'b1110, 32'd100, 32'd7);
        issue(32, 4'b1110, 32'h1234, 32'd0);
        issue(32, 4'b1111, 32'h1234, 32'h5678);

        // start with ADD while MULT is busy must be ignored
        issue(32, 4'b1101, 32'h0001_0003, 32'h0000_0100);
        repeat (4) @(negedge clock);
        start32 = 1'b1; op32 = 4'b0010; a32 = 32'd2; b32 = 32'd3;
        @(posedge clock);
        #1 start32 = 1'b0;

        // Reset in the middle of a MULT aborts it without a done pulse
        issue(32, 4'b1101, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(negedge clock);
        #2 reset32 = 1'b1;
        #1 chk_zero32("abort");
        q32.delete();
        repeat (2) @(negedge clock);
        reset32 = 1'b0;
        issue(32, 4'b0010, 32'd2, 32'd3);

        // Random traffic, WIDTH=32
        for (int i = 0; i < 50; i++)
            issue(32, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());

        // Directed and random traffic, WIDTH=8
        issue(8, 4'b1101, 32'hFF, 32'hFF);
        issue(8, 4'b1000, 32'd1, 32'h0F);
        issue(8, 4'b0010, 32'h7F, 32'h01);
        issue(8, 4'b1110, 32'h5A, 32'd0);
        for (int i = 0; i < 30; i++)
            issue(8, 4'($urandom_range(0, 15)), $urandom, $urandom);

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", 32'(q32.size() + q8.size()), 32'd0);
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
